// File: rtl/collision_pkg.sv
// Shared helpers for the collision matrix: pair indexing and index-width sizing.
package collision_pkg;

   function automatic int pair_idx(input int a, input int t, input int nt);
      return a * nt + t;
   endfunction

   // A one-entry dimension still needs a 1-bit index port.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/collision_matrix_ctrl_fifo.sv
// Single-clock event FIFO. The head is read straight from the storage registers.
module sync_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   logic [DEPTH-1:0][WIDTH-1:0] mem;
   logic [PW-1:0]               wr_ptr, rd_ptr;
   logic [CW-1:0]               count;
   logic                        push_ok, pop_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   // A push into a full FIFO is legal when the head leaves in the same cycle.
   assign push_ok = push && (!full || pop);
   assign pop_ok  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!resetN) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push_ok) - CW'(pop_ok);
      end
   end

endmodule

// File: rtl/collision_matrix_ctrl.sv
// Per-frame actor x target collision detector with first-hit pulses, frame
// snapshot and a queued {actor,target} event stream.
module collision_matrix_ctrl
   import collision_pkg::*;
#(
   parameter int                 NA        = 2,
   parameter int                 NT        = 4,
   parameter logic [NA*NT-1:0]   PAIR_MASK = '1,
   parameter int                 DEPTH     = 8
) (
   input  logic                  clk,
   input  logic                  resetN,
   input  logic                  startOfFrame,
   input  logic [NA-1:0]         drawing_request_act,
   input  logic [NT-1:0]         drawing_request_tgt,
   input  logic [NA*NT-1:0]      pair_en,
   output logic                  collision,
   output logic [NA*NT-1:0]      hit_pulse,
   output logic                  SingleHitPulse,
   output logic [NA*NT-1:0]      frame_hits,
   output logic                  evt_valid,
   input  logic                  evt_ready,
   output logic [idx_w(NA)-1:0]  evt_actor,
   output logic [idx_w(NT)-1:0]  evt_target,
   output logic                  overflow
);
   localparam int NP = NA * NT;
   localparam int AW = idx_w(NA);
   localparam int TW = idx_w(NT);

   typedef struct packed {
      logic [AW-1:0] actor;
      logic [TW-1:0] target;
   } coll_evt_t;

   logic [NP-1:0] raw, new_hit, flag, pending, pend_clr, sel_oh;
   logic          sel_vld, push, pop, fifo_full, fifo_empty;
   coll_evt_t     sel_evt, head;

   for (genvar a = 0; a < NA; a++) begin : g_act
      for (genvar t = 0; t < NT; t++) begin : g_tgt
         localparam int P = pair_idx(a, t, NT);
         assign raw[P] = drawing_request_act[a] & drawing_request_tgt[t]
                       & PAIR_MASK[P] & pair_en[P];
      end
   end

   // At frame start the old flags no longer suppress: every overlap is a first hit.
   assign new_hit = raw & ~(flag & {NP{~startOfFrame}});

   // Fixed priority: descending scan so the lowest pending index wins.
   always_comb begin
      sel_vld = 1'b0;
      sel_oh  = '0;
      sel_evt = '0;
      for (int p = NP - 1; p >= 0; p--) begin
         if (pending[p]) begin
            sel_vld        = 1'b1;
            sel_oh         = '0;
            sel_oh[p]      = 1'b1;
            sel_evt.actor  = AW'(p / NT);
            sel_evt.target = TW'(p % NT);
         end
      end
   end

   assign pop      = evt_valid && evt_ready;
   assign push     = sel_vld && (!fifo_full || pop);
   assign pend_clr = push ? sel_oh : '0;

   always_ff @(posedge clk) begin
      if (!resetN) begin
         collision      <= 1'b0;
         hit_pulse      <= '0;
         SingleHitPulse <= 1'b0;
         frame_hits     <= '0;
         flag           <= '0;
         pending        <= '0;
         overflow       <= 1'b0;
      end else begin
         collision      <= |raw;
         hit_pulse      <= new_hit;
         SingleHitPulse <= |new_hit;
         if (startOfFrame) begin
            frame_hits <= flag;
            flag       <= raw;
            // Whatever could not be queued last frame is lost now.
            pending    <= new_hit;
            if (|(pending & ~pend_clr)) overflow <= 1'b1;
         end else begin
            flag    <= flag | raw;
            pending <= (pending & ~pend_clr) | new_hit;
         end
      end
   end

   sync_fifo #(.WIDTH($bits(coll_evt_t)), .DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .resetN (resetN),
      .push   (push),
      .din    (sel_evt),
      .pop    (pop),
      .dout   (head),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   assign evt_valid  = !fifo_empty;
   assign evt_actor  = head.actor;
   assign evt_target = head.target;

endmodule

// File: tb/tb_collision_matrix_ctrl.sv
// Randomised and directed bench for collision_matrix_ctrl against a
// queue-based frame model; a second instance checks the static pair mask.
module tb_collision_matrix_ctrl;
   localparam int NA = 2, NT = 4, NP = 8, DEPTH = 8;

   logic          clk = 1'b0;
   logic          resetN, sof, ready;
   logic [NA-1:0] act;
   logic [NT-1:0] tgt;
   logic [NP-1:0] pen;

   logic          coll, single, ev, ovf;
   logic [NP-1:0] hp, fh;
   logic          ea;
   logic [1:0]    et;

   logic          m_coll, m_single, m_ev, m_ovf;
   logic [NP-1:0] m_hp, m_fh;
   logic          m_ea;
   logic [1:0]    m_et;

   int n_chk = 0, n_fail = 0;

   // model state
   bit [NP-1:0] md_flag, md_pend, md_fh, md_pulse;
   bit          md_coll, md_single, md_ovf;
   int          md_q[$];

   always #5 clk = ~clk;

   collision_matrix_ctrl #(.NA(NA), .NT(NT), .PAIR_MASK(8'hFF), .DEPTH(DEPTH)) dut (
      .clk(clk), .resetN(resetN), .startOfFrame(sof),
      .drawing_request_act(act), .drawing_request_tgt(tgt), .pair_en(pen),
      .collision(coll), .hit_pulse(hp), .SingleHitPulse(single), .frame_hits(fh),
      .evt_valid(ev), .evt_ready(ready), .evt_actor(ea), .evt_target(et),
      .overflow(ovf));

   collision_matrix_ctrl #(.NA(NA), .NT(NT), .PAIR_MASK(8'hFB), .DEPTH(DEPTH)) dut_m (
      .clk(clk), .resetN(resetN), .startOfFrame(sof),
      .drawing_request_act(act), .drawing_request_tgt(tgt), .pair_en(pen),
      .collision(m_coll), .hit_pulse(m_hp), .SingleHitPulse(m_single), .frame_hits(m_fh),
      .evt_valid(m_ev), .evt_ready(ready), .evt_actor(m_ea), .evt_target(m_et),
      .overflow(m_ovf));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock of the frame rules: overlap -> first hit this frame -> queued event.
   task automatic model_step();
      bit [NP-1:0] raw, nw;
      int          lowest;
      bit          do_pop;
      if (!resetN) begin
         md_flag = '0; md_pend = '0; md_fh = '0; md_pulse = '0;
         md_coll = 0; md_single = 0; md_ovf = 0;
         md_q.delete();
         return;
      end
      for (int p = 0; p < NP; p++) raw[p] = act[p / NT] & tgt[p % NT] & pen[p];
      nw = sof ? raw : (raw & ~md_flag);
      do_pop = (md_q.size() > 0) && ready;
      lowest = -1;
      for (int p = 0; p < NP && lowest < 0; p++) if (md_pend[p]) lowest = p;
      if (do_pop) void'(md_q.pop_front());
      if (lowest >= 0 && md_q.size() < DEPTH) begin
         md_q.push_back(lowest);
         md_pend[lowest] = 0;
      end
      md_coll = |raw; md_pulse = nw; md_single = |nw;
      if (sof) begin
         if (md_pend != 0) md_ovf = 1;
         md_fh = md_flag; md_flag = raw; md_pend = nw;
      end else begin
         md_flag |= raw; md_pend |= nw;
      end
   endtask

   task automatic compare_all();
      chk("collision", coll, md_coll);
      chk("hit_pulse", hp, md_pulse);
      chk("single", single, md_single);
      chk("frame_hits", fh, md_fh);
      chk("evt_valid", ev, md_q.size() > 0);
      chk("overflow", ovf, md_ovf);
      if (md_q.size() > 0) chk("evt_pair", ea * NT + et, md_q[0]);
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   initial begin
      int hits, cols, first_v, got[$];
      resetN = 0; sof = 0; ready = 0; pen = '1; act = 2'b01; tgt = 4'b0010;
      // reset with overlap present
      repeat (3) cyc();
      chk("rst_coll", coll, 0); chk("rst_valid", ev, 0); chk("rst_ovf", ovf, 0);
      chk("rst_hp", hp, 0);
      resetN = 1; act = 0; tgt = 0; sof = 1; cyc(); sof = 0;

      // pair 1 overlap for 5 cycles
      act = 2'b01; tgt = 4'b0010; cols = 0; hits = 0; first_v = -1;
      for (int c = 1; c <= 6; c++) begin
         if (c == 6) act = 0;
         cyc();
         cols += coll; hits += hp[1] + single;
         if (ev && first_v < 0) first_v = c;
      end
      chk("coll_cycles", cols, 5);
      chk("pulse_once", hits, 2);
      chk("evt_latency", first_v, 2);
      chk("evt_01", {ea, et}, 3'b001);
      ready = 1; cyc(); ready = 0;

      // overlap across start of frame
      act = 2'b01; tgt = 4'b0010;
      cyc(); chk("no_repulse", hp, 0);
      sof = 1; cyc(); sof = 0;
      chk("sof_pulse", hp, 8'h02);
      chk("sof_fh", fh, 8'h02);
      cyc(); chk("sof_once", hp, 0);
      act = 0; ready = 1; repeat (4) cyc();

      // simultaneous first hits on 1,6,7 with pair_en restricting the rest
      sof = 1; cyc(); sof = 0;
      pen = 8'hC2; act = 2'b11; tgt = 4'b1110; cyc();
      chk("tri_pulse", hp, 8'hC2);
      act = 0; got.delete();
      for (int c = 0; c < 8; c++) begin
         if (ev) got.push_back(ea * NT + et);
         cyc();
      end
      chk("tri_n", got.size(), 3);
      if (got.size() == 3) begin
         chk("tri_0", got[0], 1); chk("tri_1", got[1], 6); chk("tri_2", got[2], 7);
      end
      pen = '1;

      // fill FIFO, strand a pending hit, then drop it at frame start
      ready = 0; sof = 1; cyc(); sof = 0;
      act = 2'b11; tgt = 4'b1111; cyc(); act = 0;
      repeat (10) cyc();
      sof = 1; cyc(); sof = 0;
      act = 2'b01; tgt = 4'b0001; cyc(); act = 0;
      repeat (3) cyc();
      chk("ovf_before", ovf, 0);
      sof = 1; cyc(); sof = 0;
      chk("ovf_set", ovf, 1);
      ready = 1; got.delete();
      for (int c = 0; c < 12; c++) begin
         if (ev) got.push_back(ea * NT + et);
         cyc();
      end
      chk("drain_n", got.size(), 8);
      foreach (got[i]) chk("drain_ord", got[i], i);

      // runtime disable of pair 2
      pen = 8'hFB; sof = 1; cyc(); sof = 0;
      act = 2'b01; tgt = 4'b0100;
      repeat (3) begin cyc(); chk("en_coll", coll, 0); chk("en_hp", hp, 0); end
      act = 0; sof = 1; cyc(); sof = 0;
      chk("en_fh2", fh[2], 0); chk("en_valid", ev, 0);

      // static mask on pair 2 in the second instance
      pen = '1; act = 2'b01; tgt = 4'b0100;
      repeat (2) begin
         cyc(); chk("mask_coll", m_coll, 0); chk("mask_hp", m_hp, 0); chk("mask_single", m_single, 0);
      end
      act = 0; sof = 1; cyc(); sof = 0;
      chk("mask_fh2", m_fh[2], 0);
      act = 2'b01; tgt = 4'b0010; cyc();
      chk("mask_pair1", m_coll, 1);
      act = 0;

      // random traffic incl. mid-frame resets
      for (int c = 0; c < 1500; c++) begin
         resetN = ($urandom_range(0, 299) != 0);
         sof    = ($urandom_range(0, 19) == 0);
         act    = NA'($urandom);
         tgt    = ($urandom_range(0, 2) == 0) ? NT'($urandom) : '0;
         pen    = ($urandom_range(0, 3) == 0) ? NP'($urandom) : '1;
         ready  = ($urandom_range(0, 3) == 0);
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
